// File: rtl/dsp_timing_ctrl.sv
// dsp_timing_ctrl: radar frame sequencer feeding dsp_top with CPI begin/end,
// per-chirp PRI pulses and a sample-gate window. Timing config is captured
// only at CPI boundaries so a CPI always runs with one consistent setup.
module dsp_timing_ctrl #(
  parameter int PRI_W   = 16,
  parameter int CHIRP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_oneshot,
  input  logic [PRI_W-1:0]   i_pri_period,
  input  logic [PRI_W-1:0]   i_smp_start,
  input  logic [PRI_W-1:0]   i_smp_len,
  input  logic [CHIRP_W-1:0] i_chirp_num,
  input  logic [PRI_W-1:0]   i_cpi_gap,
  output logic               o_cpib,
  output logic               o_cpie,
  output logic               o_pri,
  output logic               o_smp_gate,
  output logic [CHIRP_W-1:0] o_chirp_idx,
  output logic               o_busy,
  output logic               o_cfg_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Legality of a timing set; the window end is formed one bit wider so
  // smp_start + smp_len cannot wrap and sneak past the period check.
  function automatic logic cfg_legal(
    input logic [PRI_W-1:0]   per,
    input logic [PRI_W-1:0]   ss,
    input logic [PRI_W-1:0]   len,
    input logic [CHIRP_W-1:0] num
  );
    logic [PRI_W:0] win_end;
    win_end = {1'b0, ss} + {1'b0, len};
    return (per >= PRI_W'(2)) && (len != '0) && (num != '0) &&
           (win_end <= {1'b0, per});
  endfunction

  logic [1:0]         state_q, state_d;
  logic [PRI_W-1:0]   pcnt_q, pcnt_d;
  logic [CHIRP_W-1:0] chirp_q, chirp_d;
  logic [PRI_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PRI_W-1:0]   per_q, per_d;
  logic [PRI_W-1:0]   ss_q, ss_d;
  logic [PRI_W-1:0]   len_q, len_d;
  logic [CHIRP_W-1:0] num_q, num_d;
  logic [PRI_W-1:0]   gap_q, gap_d;
  logic               oneshot_q, oneshot_d;
  logic               stop_q, stop_d;
  logic               err_q, err_d;
  logic               cpib_q, cpib_d;
  logic               cpie_q, cpie_d;
  logic               pri_q, pri_d;
  logic               gate_q, gate_d;
  logic               busy_q, busy_d;
  logic [CHIRP_W-1:0] idx_q, idx_d;
  logic               launch;
  logic               run_d;
  logic [PRI_W:0]     win_end_d;

  // Next-state logic; outputs are decoded from the next state so every
  // output is a flop that lines up with the counters it describes.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    chirp_d   = chirp_q;
    gap_cnt_d = gap_cnt_q;
    per_d     = per_q;
    ss_d      = ss_q;
    len_d     = len_q;
    num_d     = num_q;
    gap_d     = gap_q;
    oneshot_d = oneshot_q;
    stop_d    = stop_q;
    err_d     = err_q;
    launch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (i_start) launch = 1'b1;
      end
      S_RUN: begin
        stop_d = stop_q | i_stop;
        if (pcnt_q == per_q - 1'b1) begin
          pcnt_d = '0;
          if (chirp_q == num_q - 1'b1) begin
            // Last cycle of the CPI: o_cpie is showing now.
            chirp_d = '0;
            if (oneshot_q || stop_d) begin
              state_d = S_IDLE;
              stop_d  = 1'b0;
            end else if (gap_q == '0) begin
              launch = 1'b1;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            chirp_d = chirp_q + 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        stop_d = stop_q | i_stop;
        if (gap_cnt_q == gap_q - 1'b1) begin
          if (stop_d) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            launch = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
    endcase

    // A new CPI (first or continued) samples and checks the live config.
    if (launch) begin
      if (cfg_legal(i_pri_period, i_smp_start, i_smp_len, i_chirp_num)) begin
        per_d     = i_pri_period;
        ss_d      = i_smp_start;
        len_d     = i_smp_len;
        num_d     = i_chirp_num;
        gap_d     = i_cpi_gap;
        oneshot_d = i_oneshot;
        state_d   = S_RUN;
        pcnt_d    = '0;
        chirp_d   = '0;
        gap_cnt_d = '0;
        err_d     = 1'b0;
        // A stop arriving with the start still lets exactly one CPI run.
        if (state_q == S_IDLE) stop_d = i_stop;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        chirp_d = '0;
        pcnt_d  = '0;
        stop_d  = 1'b0;
      end
    end

    run_d     = (state_d == S_RUN);
    win_end_d = {1'b0, ss_d} + {1'b0, len_d};
    pri_d     = run_d && (pcnt_d == '0);
    cpib_d    = pri_d && (chirp_d == '0);
    cpie_d    = run_d && (pcnt_d == per_d - 1'b1) && (chirp_d == num_d - 1'b1);
    gate_d    = run_d && (pcnt_d >= ss_d) && ({1'b0, pcnt_d} < win_end_d);
    busy_d    = (state_d != S_IDLE);
    idx_d     = chirp_d;
  end

  // State, latched config and registered outputs; reset aborts any CPI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pcnt_q    <= '0;
      chirp_q   <= '0;
      gap_cnt_q <= '0;
      per_q     <= '0;
      ss_q      <= '0;
      len_q     <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      oneshot_q <= 1'b0;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
      cpib_q    <= 1'b0;
      cpie_q    <= 1'b0;
      pri_q     <= 1'b0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      chirp_q   <= chirp_d;
      gap_cnt_q <= gap_cnt_d;
      per_q     <= per_d;
      ss_q      <= ss_d;
      len_q     <= len_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      oneshot_q <= oneshot_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
      cpib_q    <= cpib_d;
      cpie_q    <= cpie_d;
      pri_q     <= pri_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
    end
  end

  assign o_cpib      = cpib_q;
  assign o_cpie      = cpie_q;
  assign o_pri       = pri_q;
  assign o_smp_gate  = gate_q;
  assign o_chirp_idx = idx_q;
  assign o_busy      = busy_q;
  assign o_cfg_err   = err_q;

endmodule

// File: tb/tb_dsp_timing_ctrl.sv
// Bench for dsp_timing_ctrl: directed scenarios plus random traffic compared
// cycle by cycle with a timeline model (flat cycle offset within a CPI/gap).
module tb_dsp_timing_ctrl;
  localparam int PRI_W   = 16;
  localparam int CHIRP_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start, i_stop, i_oneshot;
  logic [PRI_W-1:0]   i_pri_period, i_smp_start, i_smp_len, i_cpi_gap;
  logic [CHIRP_W-1:0] i_chirp_num;
  logic               o_cpib, o_cpie, o_pri, o_smp_gate, o_busy, o_cfg_err;
  logic [CHIRP_W-1:0] o_chirp_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int s;
  int first_cpie;
  int cpib_q[$];

  // Model: mode 0 idle, 1 in CPI, 2 in gap; t = cycle offset within it.
  int m_mode, m_t, m_per, m_ss, m_len, m_num, m_gap;
  bit m_one, m_pend, m_err;

  always #5 clk = ~clk;

  dsp_timing_ctrl #(.PRI_W(PRI_W), .CHIRP_W(CHIRP_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_oneshot(i_oneshot), .i_pri_period(i_pri_period),
    .i_smp_start(i_smp_start), .i_smp_len(i_smp_len),
    .i_chirp_num(i_chirp_num), .i_cpi_gap(i_cpi_gap),
    .o_cpib(o_cpib), .o_cpie(o_cpie), .o_pri(o_pri),
    .o_smp_gate(o_smp_gate), .o_chirp_idx(o_chirp_idx),
    .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit legal(int per, int ss, int len, int num);
    return (per >= 2) && (len >= 1) && (num >= 1) && (ss + len <= per);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_t = 0; m_per = 0; m_ss = 0; m_len = 0; m_num = 0;
    m_gap = 0; m_one = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic m_launch(input bit from_idle);
    if (legal(int'(i_pri_period), int'(i_smp_start), int'(i_smp_len), int'(i_chirp_num))) begin
      m_per = int'(i_pri_period); m_ss = int'(i_smp_start); m_len = int'(i_smp_len);
      m_num = int'(i_chirp_num); m_gap = int'(i_cpi_gap); m_one = i_oneshot;
      m_mode = 1; m_t = 0; m_err = 0;
      if (from_idle) m_pend = i_stop;
    end else begin
      m_err = 1; m_mode = 0; m_pend = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs just sampled.
  task automatic m_step();
    case (m_mode)
      0: begin
        m_pend = 0;
        if (i_start) m_launch(1'b1);
      end
      1: begin
        m_pend = m_pend | i_stop;
        if (m_t == m_per * m_num - 1) begin
          if (m_one || m_pend) begin m_mode = 0; m_pend = 0; end
          else if (m_gap == 0) m_launch(1'b0);
          else begin m_mode = 2; m_t = 0; end
        end else m_t++;
      end
      default: begin
        m_pend = m_pend | i_stop;
        if (m_t == m_gap - 1) begin
          if (m_pend) begin m_mode = 0; m_pend = 0; end
          else m_launch(1'b0);
        end else m_t++;
      end
    endcase
  endtask

  function automatic logic [31:0] m_expect();
    logic cpib, cpie, pri, gate, busy;
    logic [CHIRP_W-1:0] idx;
    int k;
    cpib = 0; cpie = 0; pri = 0; gate = 0; idx = '0;
    busy = (m_mode != 0);
    if (m_mode == 1) begin
      k    = m_t % m_per;
      idx  = CHIRP_W'(m_t / m_per);
      pri  = (k == 0);
      cpib = (m_t == 0);
      cpie = (m_t == m_per * m_num - 1);
      gate = (k >= m_ss) && (k < m_ss + m_len);
    end
    return {18'd0, cpib, cpie, pri, gate, busy, m_err, idx};
  endfunction

  function automatic logic [31:0] observed();
    return {18'd0, o_cpib, o_cpie, o_pri, o_smp_gate, o_busy, o_cfg_err, o_chirp_idx};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    @(negedge clk);
    cyc++;
    check_eq("outputs", observed(), m_expect());
    if (o_cpie && first_cpie < 0) first_cpie = cyc;
    if (o_cpib) cpib_q.push_back(cyc);
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_cfg(input int per, input int ss, input int len, input int num,
                         input int gap, input bit one);
    i_pri_period = PRI_W'(per); i_smp_start = PRI_W'(ss); i_smp_len = PRI_W'(len);
    i_chirp_num = CHIRP_W'(num); i_cpi_gap = PRI_W'(gap); i_oneshot = one;
  endtask

  task automatic start_cpi();
    i_start = 1'b1;
    first_cpie = -1;
    cpib_q.delete();
    cycle();
    s = cyc;
  endtask

  initial begin
    rst = 1'b1; i_start = 0; i_stop = 0;
    set_cfg(0, 0, 0, 0, 0, 0);
    m_reset();
    run(3);
    rst = 1'b0;
    run(2);

    // Continuous run: cpie at cycle 40, next cpib at 44 (cpib at 1).
    set_cfg(10, 2, 5, 4, 3, 0);
    start_cpi();
    run(50);
    check_eq("cpie_time", first_cpie - s, 39);
    check_eq("cpib2_time", (cpib_q.size() > 1) ? cpib_q[1] - s : -1, 43);
    i_stop = 1'b1;
    run(60);
    check_eq("idle_after_stop", o_busy, 0);

    // Oneshot: one CPI, then idle.
    set_cfg(10, 2, 5, 4, 3, 1);
    start_cpi();
    run(50);
    check_eq("oneshot_cpib_cnt", cpib_q.size(), 1);
    check_eq("oneshot_busy", o_busy, 0);

    // Stop at chirp 1: CPI completes, then idle with no gap.
    set_cfg(10, 2, 5, 4, 3, 0);
    start_cpi();
    run(12);
    check_eq("stop_at_chirp1", o_chirp_idx, 1);
    i_stop = 1'b1;
    run(40);
    check_eq("stop_cpie_time", first_cpie - s, 39);
    check_eq("stop_cpib_cnt", cpib_q.size(), 1);
    check_eq("stop_busy", o_busy, 0);

    // Illegal config, then a legal start clears the flag.
    set_cfg(10, 8, 5, 4, 3, 0);
    start_cpi();
    check_eq("illegal_err", o_cfg_err, 1);
    check_eq("illegal_busy", o_busy, 0);
    run(3);
    set_cfg(10, 2, 5, 1, 0, 1);
    start_cpi();
    check_eq("legal_err_clr", o_cfg_err, 0);
    check_eq("legal_busy", o_busy, 1);
    run(15);

    // Minimum CPI, continuous with no gap.
    set_cfg(2, 0, 1, 1, 0, 0);
    start_cpi();
    run(9);
    check_eq("min_cpib_cnt", cpib_q.size(), 5);
    i_stop = 1'b1;
    run(5);

    // Config changed mid-CPI applies only from the next cpib.
    set_cfg(10, 2, 5, 2, 0, 0);
    start_cpi();
    run(5);
    set_cfg(6, 1, 2, 3, 2, 0);
    run(40);
    i_stop = 1'b1;
    run(30);

    // Reset at chirp 2 aborts immediately; fresh start begins at chirp 0.
    set_cfg(10, 2, 5, 4, 3, 0);
    start_cpi();
    run(20);
    check_eq("pre_rst_chirp", o_chirp_idx, 2);
    rst = 1'b1;
    #1;
    check_eq("rst_async", observed(), 0);
    m_reset();
    run(2);
    rst = 1'b0;
    start_cpi();
    check_eq("restart_idx", o_chirp_idx, 0);
    check_eq("restart_cpib", o_cpib, 1);
    run(10);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0)
        set_cfg($urandom_range(1, 12), $urandom_range(0, 8), $urandom_range(0, 6),
                $urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
      i_start = ($urandom_range(0, 19) == 0);
      i_stop  = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
